// File: rtl/ro_puf_controller.sv
// Ring-oscillator PUF measurement controller: applies a challenge, gates both rings
// for a fixed window, counts synchronized rising edges and compares the two counts.
module ro_puf_controller #(
   parameter int STAGES     = 8,
   parameter int CNT_W      = 16,
   parameter int WINDOW     = 1000,
   parameter int SETTLE_CYC = 4
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [STAGES-1:0] CHALLENGE,
   input  logic              RO_A_PULSE,
   input  logic              RO_B_PULSE,
   output logic [STAGES-1:0] RO_SEL,
   output logic              RO_A_EN,
   output logic              RO_B_EN,
   output logic              BUSY,
   output logic              DONE,
   output logic              RESPONSE,
   output logic              TIE,
   output logic [CNT_W-1:0]  COUNT_A,
   output logic [CNT_W-1:0]  COUNT_B
);

   // Timer must hold both WINDOW-1 (CNT_W bits) and SETTLE_CYC-1 (8 bits).
   localparam int TMR_W = (CNT_W > 8) ? CNT_W : 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      RUN     = 3'd2,
      DRAIN   = 3'd3,
      COMPARE = 3'd4,
      DONE_ST = 3'd5
   } state_t;

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [2:0]        sync_a_q;
   logic [2:0]        sync_b_q;
   logic [CNT_W-1:0]  cnt_a_q;
   logic [CNT_W-1:0]  cnt_b_q;
   logic [CNT_W-1:0]  cnt_a_d;
   logic [CNT_W-1:0]  cnt_b_d;
   logic [STAGES-1:0] sel_q;
   logic              en_q;
   logic              busy_q;
   logic              done_q;
   logic              resp_q;
   logic              tie_q;
   logic              edge_a_s;
   logic              edge_b_s;
   logic              counting_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
      logic [CNT_W-1:0] r;
      if (hit && (v != {CNT_W{1'b1}})) begin
         r = v + CNT_W'(1);
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Edge detect on the synchronized ring outputs and saturating counter next-state.
   always_comb begin
      edge_a_s   = sync_a_q[1] & ~sync_a_q[2];
      edge_b_s   = sync_b_q[1] & ~sync_b_q[2];
      counting_s = (state_q == RUN) || (state_q == DRAIN);
      if (counting_s) begin
         cnt_a_d = sat_inc(cnt_a_q, edge_a_s);
         cnt_b_d = sat_inc(cnt_b_q, edge_b_s);
      end else begin
         cnt_a_d = cnt_a_q;
         cnt_b_d = cnt_b_q;
      end
   end

   // Two-flop synchronizers plus one history flop for the edge detector.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_a_q <= 3'b000;
         sync_b_q <= 3'b000;
      end else begin
         sync_a_q <= {sync_a_q[1:0], RO_A_PULSE};
         sync_b_q <= {sync_b_q[1:0], RO_B_PULSE};
      end
   end

   // Measurement sequencer with all outputs registered.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         timer_q <= {TMR_W{1'b0}};
         cnt_a_q <= {CNT_W{1'b0}};
         cnt_b_q <= {CNT_W{1'b0}};
         sel_q   <= {STAGES{1'b0}};
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         resp_q  <= 1'b0;
         tie_q   <= 1'b0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               en_q   <= 1'b0;
               if (START) begin
                  sel_q   <= CHALLENGE;
                  cnt_a_q <= {CNT_W{1'b0}};
                  cnt_b_q <= {CNT_W{1'b0}};
                  timer_q <= TMR_W'(SETTLE_CYC - 1);
                  busy_q  <= 1'b1;
                  state_q <= SETTLE;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            SETTLE: begin
               if (timer_q == {TMR_W{1'b0}}) begin
                  timer_q <= TMR_W'(WINDOW - 1);
                  en_q    <= 1'b1;
                  state_q <= RUN;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            RUN: begin
               if (timer_q == {TMR_W{1'b0}}) begin
                  timer_q <= TMR_W'(2);
                  en_q    <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            DRAIN: begin
               // Three idle-ring cycles let edges still inside the synchronizer reach the counters.
               if (timer_q == {TMR_W{1'b0}}) begin
                  state_q <= COMPARE;
               end else begin
                  timer_q <= timer_q - TMR_W'(1);
               end
            end
            COMPARE: begin
               resp_q  <= (cnt_a_q > cnt_b_q);
               tie_q   <= (cnt_a_q == cnt_b_q);
               done_q  <= 1'b1;
               state_q <= DONE_ST;
            end
            DONE_ST: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               en_q    <= 1'b0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign RO_SEL   = sel_q;
   assign RO_A_EN  = en_q;
   assign RO_B_EN  = en_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign RESPONSE = resp_q;
   assign TIE      = tie_q;
   assign COUNT_A  = cnt_a_q;
   assign COUNT_B  = cnt_b_q;

endmodule
